hazard_unit: RTL and testbench

Pipeline hazard detector for the TSC CPU, consuming the per-instruction operand-use and result-ready information that the control unit decodes in ID. The block produces the per-stage `*_hazard_detected` signals that the control unit turns into stall and flush commands. It keeps a three-entry shadow scoreboard (EX, MEM, WB) of in-flight register writers. That scoreboard advances under the same stall/flush commands the control unit drives, so the block closes the loop with the control unit. It also raises structural hazards when the DMA engine owns the memory bus.

---
 rtl/hazard_unit_pkg.sv | 43 ++++
 rtl/hazard_sb_entry.sv | 44 ++++
 rtl/hazard_unit.sv | 98 +++++++++
 tb/tb_hazard_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the TSC CPU hazard unit: stage codes, forwarding-select
// encoding, the shadow-scoreboard entry and the comparator helpers.
package hazard_unit_pkg;

  localparam int unsigned SB_ADDR_W  = 2;
  localparam int unsigned SB_STAGE_W = 2;

  typedef enum logic [SB_STAGE_W-1:0] {
    STAGE_ID  = 2'd0,
    STAGE_EX  = 2'd1,
    STAGE_MEM = 2'd2,
    STAGE_WB  = 2'd3
  } stage_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_EX   = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_WB   = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic                  valid;
    logic [SB_ADDR_W-1:0]  dest;
    logic [SB_STAGE_W-1:0] ready;
  } sb_entry_t;

  // Result not yet forwardable when the consumer needs it: pos + use_stage <= ready, 3-bit, no wrap.
  function automatic logic sb_hazard(input logic [SB_STAGE_W-1:0] pos,
                                     input logic [SB_STAGE_W-1:0] use_stage,
                                     input logic [SB_STAGE_W-1:0] ready);
    return ({1'b0, pos} + {1'b0, use_stage}) <= {1'b0, ready};
  endfunction

  // match[0]=EX, [1]=MEM, [2]=WB; youngest writer wins.
  function automatic fwd_sel_e fwd_encode(input logic [2:0] match);
    if (match[0]) return FWD_EX;
    if (match[1]) return FWD_MEM;
    if (match[2]) return FWD_WB;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One shadow-scoreboard slot: load/stall/flush register plus the per-source
// match and data-hazard comparators for its fixed pipeline position POS.
module hazard_sb_entry
  import hazard_unit_pkg::*;
#(
  parameter stage_e POS = STAGE_EX
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  sb_entry_t             d,
  output sb_entry_t             q,
  input  logic                  rs_use,
  input  logic [SB_ADDR_W-1:0]  rs_addr,
  input  logic [SB_STAGE_W-1:0] rs_use_stage,
  input  logic                  rt_use,
  input  logic [SB_ADDR_W-1:0]  rt_addr,
  input  logic [SB_STAGE_W-1:0] rt_use_stage,
  output logic                  rs_match,
  output logic                  rs_hazard,
  output logic                  rt_match,
  output logic                  rt_hazard
);

  // Flush outranks stall, so a flushed slot empties even while the stage is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (flush) begin
      q.valid <= 1'b0;
    end else if (!stall) begin
      q <= d;
    end
  end

  always_comb begin
    rs_match  = rs_use & q.valid & (q.dest == rs_addr);
    rt_match  = rt_use & q.valid & (q.dest == rt_addr);
    rs_hazard = rs_match & sb_hazard(POS, rs_use_stage, q.ready);
    rt_hazard = rt_match & sb_hazard(POS, rt_use_stage, q.ready);
  end

endmodule

// File: rtl/hazard_unit.sv
// TSC CPU pipeline hazard detector with a three-entry shadow scoreboard (EX/MEM/WB).
// Define HAZARD_FWD_SEL_EN to add the ID_rs_fwd_sel / ID_rt_fwd_sel outputs.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 2,
  parameter int unsigned STAGE_W    = 2
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ID_rs_addr,
  input  logic [REG_ADDR_W-1:0] ID_rt_addr,
  input  logic                  rs_use,
  input  logic                  rt_use,
  input  logic [STAGE_W-1:0]    rs_use_stage,
  input  logic [STAGE_W-1:0]    rt_use_stage,
  input  logic [REG_ADDR_W-1:0] ID_dest_addr,
  input  logic                  RegWrite,
  input  logic [STAGE_W-1:0]    write_valid_stage,
  input  logic                  ID_nop,
  input  logic                  ID_jump_taken,
  input  logic                  IF_mem_req,
  input  logic                  MEM_mem_req,
  input  logic                  IF_bus_grant,
  input  logic                  MEM_bus_grant,
  input  logic                  IFID_stall,
  input  logic                  IDEX_stall,
  input  logic                  EXMEM_stall,
  input  logic                  MEMWB_stall,
  input  logic                  IDEX_flush,
  input  logic                  EXMEM_flush,
  input  logic                  MEMWB_flush,
  output logic                  IF_hazard_detected,
  output logic                  ID_hazard_detected,
  output logic                  EX_hazard_detected,
  output logic                  MEM_hazard_detected,
  output logic                  WB_hazard_detected
`ifdef HAZARD_FWD_SEL_EN
  ,
  output logic [1:0]            ID_rs_fwd_sel,
  output logic [1:0]            ID_rt_fwd_sel
`endif
);

  sb_entry_t  sb_d_ex, sb_ex, sb_mem, sb_wb;
  logic [2:0] rs_match, rs_haz, rt_match, rt_haz;

  // A stalled ID instruction enters EX as a bubble, so no duplicate writers appear.
  assign sb_d_ex = '{valid: RegWrite & ~ID_nop & ~ID_hazard_detected,
                     dest:  ID_dest_addr,
                     ready: write_valid_stage};

  hazard_sb_entry #(.POS(STAGE_EX)) u_sb_ex (
    .clk(clk), .reset(reset), .stall(IDEX_stall), .flush(IDEX_flush),
    .d(sb_d_ex), .q(sb_ex),
    .rs_use(rs_use), .rs_addr(ID_rs_addr), .rs_use_stage(rs_use_stage),
    .rt_use(rt_use), .rt_addr(ID_rt_addr), .rt_use_stage(rt_use_stage),
    .rs_match(rs_match[0]), .rs_hazard(rs_haz[0]),
    .rt_match(rt_match[0]), .rt_hazard(rt_haz[0])
  );

  hazard_sb_entry #(.POS(STAGE_MEM)) u_sb_mem (
    .clk(clk), .reset(reset), .stall(EXMEM_stall), .flush(EXMEM_flush),
    .d(sb_ex), .q(sb_mem),
    .rs_use(rs_use), .rs_addr(ID_rs_addr), .rs_use_stage(rs_use_stage),
    .rt_use(rt_use), .rt_addr(ID_rt_addr), .rt_use_stage(rt_use_stage),
    .rs_match(rs_match[1]), .rs_hazard(rs_haz[1]),
    .rt_match(rt_match[1]), .rt_hazard(rt_haz[1])
  );

  hazard_sb_entry #(.POS(STAGE_WB)) u_sb_wb (
    .clk(clk), .reset(reset), .stall(MEMWB_stall), .flush(MEMWB_flush),
    .d(sb_mem), .q(sb_wb),
    .rs_use(rs_use), .rs_addr(ID_rs_addr), .rs_use_stage(rs_use_stage),
    .rt_use(rt_use), .rt_addr(ID_rt_addr), .rt_use_stage(rt_use_stage),
    .rs_match(rs_match[2]), .rs_hazard(rs_haz[2]),
    .rt_match(rt_match[2]), .rt_hazard(rt_haz[2])
  );

  assign ID_hazard_detected  = (|rs_haz) | (|rt_haz);
  assign IF_hazard_detected  = ID_jump_taken | (IF_mem_req & ~IF_bus_grant);
  assign MEM_hazard_detected = MEM_mem_req & ~MEM_bus_grant;
  assign EX_hazard_detected  = 1'b0;
  assign WB_hazard_detected  = 1'b0;

  // The WB slot retires next; nothing downstream consumes its contents.
  logic unused_wb;
  assign unused_wb = ^{sb_wb, IFID_stall};

`ifdef HAZARD_FWD_SEL_EN
  assign ID_rs_fwd_sel = fwd_encode(rs_match);
  assign ID_rt_fwd_sel = fwd_encode(rt_match);
`else
  logic unused_match;
  assign unused_match = ^{rs_match, rt_match};
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: expected outputs are queued as each cycle's
// stimulus is applied and compared on the following falling edge.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ID_rs_addr, ID_rt_addr, ID_dest_addr;
  logic       rs_use, rt_use, RegWrite, ID_nop, ID_jump_taken;
  logic [1:0] rs_use_stage, rt_use_stage, write_valid_stage;
  logic       IF_mem_req, MEM_mem_req, IF_bus_grant, MEM_bus_grant;
  logic       IFID_stall, IDEX_stall, EXMEM_stall, MEMWB_stall;
  logic       IDEX_flush, EXMEM_flush, MEMWB_flush;
  logic       IF_hazard_detected, ID_hazard_detected, EX_hazard_detected;
  logic       MEM_hazard_detected, WB_hazard_detected;
  logic [1:0] rs_fwd_obs, rt_fwd_obs;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  string      tag_q[$];
  logic [6:0] exp_q[$];   // {IF, ID, MEM, rs_fwd[1:0], rt_fwd[1:0]}

  always #5 clk = ~clk;

  hazard_unit #(.REG_ADDR_W(2), .STAGE_W(2)) dut (
    .clk(clk), .reset(reset),
    .ID_rs_addr(ID_rs_addr), .ID_rt_addr(ID_rt_addr),
    .rs_use(rs_use), .rt_use(rt_use),
    .rs_use_stage(rs_use_stage), .rt_use_stage(rt_use_stage),
    .ID_dest_addr(ID_dest_addr), .RegWrite(RegWrite),
    .write_valid_stage(write_valid_stage), .ID_nop(ID_nop),
    .ID_jump_taken(ID_jump_taken),
    .IF_mem_req(IF_mem_req), .MEM_mem_req(MEM_mem_req),
    .IF_bus_grant(IF_bus_grant), .MEM_bus_grant(MEM_bus_grant),
    .IFID_stall(IFID_stall), .IDEX_stall(IDEX_stall),
    .EXMEM_stall(EXMEM_stall), .MEMWB_stall(MEMWB_stall),
    .IDEX_flush(IDEX_flush), .EXMEM_flush(EXMEM_flush), .MEMWB_flush(MEMWB_flush),
    .IF_hazard_detected(IF_hazard_detected), .ID_hazard_detected(ID_hazard_detected),
    .EX_hazard_detected(EX_hazard_detected), .MEM_hazard_detected(MEM_hazard_detected),
    .WB_hazard_detected(WB_hazard_detected)
`ifdef HAZARD_FWD_SEL_EN
    ,
    .ID_rs_fwd_sel(rs_fwd_obs), .ID_rt_fwd_sel(rt_fwd_obs)
`endif
  );

`ifndef HAZARD_FWD_SEL_EN
  assign rs_fwd_obs = 2'd0;
  assign rt_fwd_obs = 2'd0;
`endif

  task automatic check_eq(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : scoreboard_check
    string      t;
    logic [6:0] e;
    if (exp_q.size() != 0) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check_eq({t, ".IF"},  {1'b0, IF_hazard_detected},  {1'b0, e[6]});
      check_eq({t, ".ID"},  {1'b0, ID_hazard_detected},  {1'b0, e[5]});
      check_eq({t, ".EX"},  {1'b0, EX_hazard_detected},  2'd0);
      check_eq({t, ".MEM"}, {1'b0, MEM_hazard_detected}, {1'b0, e[4]});
      check_eq({t, ".WB"},  {1'b0, WB_hazard_detected},  2'd0);
`ifdef HAZARD_FWD_SEL_EN
      check_eq({t, ".rs_fwd"}, rs_fwd_obs, e[3:2]);
      check_eq({t, ".rt_fwd"}, rt_fwd_obs, e[1:0]);
`endif
    end
  end

  task automatic idle();
    ID_rs_addr = '0; ID_rt_addr = '0; ID_dest_addr = '0;
    rs_use = 1'b0; rt_use = 1'b0; rs_use_stage = '0; rt_use_stage = '0;
    RegWrite = 1'b0; write_valid_stage = '0; ID_nop = 1'b0; ID_jump_taken = 1'b0;
    IF_mem_req = 1'b0; MEM_mem_req = 1'b0; IF_bus_grant = 1'b1; MEM_bus_grant = 1'b1;
    IFID_stall = 1'b0; IDEX_stall = 1'b0; EXMEM_stall = 1'b0; MEMWB_stall = 1'b0;
    IDEX_flush = 1'b0; EXMEM_flush = 1'b0; MEMWB_flush = 1'b0;
  endtask

  task automatic instr(input logic [1:0] rs, input logic [1:0] rt,
                       input logic rsu, input logic rtu,
                       input logic [1:0] rss, input logic [1:0] rts,
                       input logic [1:0] dest, input logic rw, input logic [1:0] wvs);
    ID_rs_addr = rs; ID_rt_addr = rt; rs_use = rsu; rt_use = rtu;
    rs_use_stage = rss; rt_use_stage = rts;
    ID_dest_addr = dest; RegWrite = rw; write_valid_stage = wvs;
  endtask

  // Queue this cycle's expectation, then advance to just after the next rising edge.
  task automatic cycle(input string tag, input logic ifh, input logic idh, input logic memh,
                       input logic [1:0] rsf, input logic [1:0] rtf);
    tag_q.push_back(tag);
    exp_q.push_back({ifh, idh, memh, rsf, rtf});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 3; i++) cycle("drain", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    cycle("reset", 0, 0, 0, 2'd0, 2'd0);

    // ADD r1 (ready=WB) then reader of r1 at ID: three stall cycles with bubbles
    idle(); instr(2'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd1, 1, 2'd3);
    cycle("t1_prod", 0, 0, 0, 2'd0, 2'd0);
    idle(); instr(2'd1, 2'd3, 1, 0, 2'd0, 2'd0, 2'd2, 1, 2'd3);
    cycle("t1_c1", 0, 1, 0, 2'd1, 2'd0);
    cycle("t1_c2", 0, 1, 0, 2'd2, 2'd0);
    cycle("t1_c3", 0, 1, 0, 2'd3, 2'd0);
    ID_nop = 1'b1;
    cycle("t1_release", 0, 0, 0, 2'd0, 2'd0);
    idle(); instr(2'd2, 2'd0, 1, 0, 2'd0, 2'd0, 2'd0, 0, 2'd0);
    cycle("t1_bubble", 0, 0, 0, 2'd0, 2'd0);
    drain();

    // ready=EX consumed at EX: forwardable, no stall
    idle(); instr(2'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd1, 1, 2'd1);
    cycle("t2_prod", 0, 0, 0, 2'd0, 2'd0);
    idle(); instr(2'd1, 2'd0, 1, 0, 2'd1, 2'd0, 2'd0, 0, 2'd0);
    cycle("t2_ex", 0, 0, 0, 2'd1, 2'd0);
    cycle("t2_mem", 0, 0, 0, 2'd2, 2'd0);
    drain();

    // LWD r2 (ready=MEM) then BEQ r3,r2 at ID: two stall cycles
    idle(); instr(2'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd2, 1, 2'd2);
    cycle("t3_lwd", 0, 0, 0, 2'd0, 2'd0);
    idle(); instr(2'd3, 2'd2, 1, 1, 2'd0, 2'd0, 2'd0, 0, 2'd0);
    cycle("t3_c1", 0, 1, 0, 2'd0, 2'd1);
    cycle("t3_c2", 0, 1, 0, 2'd0, 2'd2);
    cycle("t3_c3", 0, 0, 0, 2'd0, 2'd3);
    drain();

    // r0 behaves like any other register
    idle(); instr(2'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 2'd3);
    cycle("r0_prod", 0, 0, 0, 2'd0, 2'd0);
    idle(); instr(2'd0, 2'd0, 1, 0, 2'd0, 2'd0, 2'd0, 0, 2'd0);
    cycle("r0_dep", 0, 1, 0, 2'd1, 2'd0);
    drain();

    // DMA owns the bus for 4 cycles; scoreboard holds with a writer parked in MEM
    idle(); instr(2'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd1, 1, 2'd3);
    cycle("t4_prod", 0, 0, 0, 2'd0, 2'd0);
    idle();
    cycle("t4_ex", 0, 0, 0, 2'd0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      idle(); instr(2'd1, 2'd0, 1, 0, 2'd1, 2'd0, 2'd0, 0, 2'd0);
      MEM_mem_req = 1'b1; MEM_bus_grant = 1'b0;
      IFID_stall = 1'b1; IDEX_stall = 1'b1; EXMEM_stall = 1'b1; MEMWB_stall = 1'b1;
      cycle("t4_bus", 0, 1, 1, 2'd2, 2'd0);
    end
    idle(); instr(2'd1, 2'd0, 1, 0, 2'd1, 2'd0, 2'd0, 0, 2'd0);
    cycle("t4_release", 0, 1, 0, 2'd2, 2'd0);
    cycle("t4_wb", 0, 0, 0, 2'd3, 2'd0);
    drain();

    // Taken jump: IF hazard now, flushed slot arrives as a bubble and is never tracked
    idle(); ID_jump_taken = 1'b1;
    cycle("t5_jump", 1, 0, 0, 2'd0, 2'd0);
    idle(); instr(2'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd3, 1, 2'd3); ID_nop = 1'b1;
    cycle("t5_flushed", 0, 0, 0, 2'd0, 2'd0);
    idle(); instr(2'd3, 2'd0, 1, 0, 2'd0, 2'd0, 2'd0, 0, 2'd0);
    cycle("t5_check", 0, 0, 0, 2'd0, 2'd0);
    idle(); IF_mem_req = 1'b1; IF_bus_grant = 1'b0;
    cycle("t5_ifbus", 1, 0, 0, 2'd0, 2'd0);
    drain();

    // Flush and stall together on ID/EX: the EX slot empties
    idle(); instr(2'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd2, 1, 2'd3);
    cycle("t6_prod", 0, 0, 0, 2'd0, 2'd0);
    idle(); instr(2'd2, 2'd0, 1, 0, 2'd0, 2'd0, 2'd0, 0, 2'd0);
    IDEX_stall = 1'b1; IDEX_flush = 1'b1;
    cycle("t6_flush", 0, 1, 0, 2'd1, 2'd0);
    idle(); instr(2'd2, 2'd0, 1, 0, 2'd0, 2'd0, 2'd0, 0, 2'd0);
    cycle("t6_mem", 0, 1, 0, 2'd2, 2'd0);
    drain();

    // Reset pulsed mid-hazard clears the scoreboard on that edge
    idle(); instr(2'd0, 2'd0, 0, 0, 2'd0, 2'd0, 2'd1, 1, 2'd3);
    cycle("t7_prod", 0, 0, 0, 2'd0, 2'd0);
    idle(); instr(2'd1, 2'd0, 1, 0, 2'd0, 2'd0, 2'd0, 0, 2'd0);
    cycle("t7_hazard", 0, 1, 0, 2'd1, 2'd0);
    reset = 1'b1;
    cycle("t7_in_reset", 0, 1, 0, 2'd2, 2'd0);
    reset = 1'b0;
    cycle("t7_after", 0, 0, 0, 2'd0, 2'd0);
    drain();

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
